// File: rtl/useq_pkg.sv
// useq_pkg: shared definitions for the microcode sequencer.
//   - opcode encodings
//   - microword field positions
//   - sequencer FSM state encoding
//
// Microword layout (32 bits):
//   [31:28] op        4-bit opcode
//   [27:19] target    9-bit jump/call target
//   [18:16] cond_sel  bit 2 inverts, bits 1:0 select one of the four conditions
//   [15:0]  imm       immediate (LED value, loop count or wait length)
// cond_sel is 3 bits wide so that a 4-bit op, 9-bit target and 16-bit imm all fit in
// 32 bits. Its upper selector bit was never used by JCOND anyway.
package useq_pkg;

   localparam int unsigned OP_HI   = 31;
   localparam int unsigned OP_LO   = 28;
   localparam int unsigned TGT_HI  = 27;
   localparam int unsigned TGT_LO  = 19;
   localparam int unsigned CSEL_HI = 18;
   localparam int unsigned CSEL_LO = 16;
   localparam int unsigned IMM_HI  = 15;
   localparam int unsigned IMM_LO  = 0;

   localparam logic [3:0] OP_NOP   = 4'd0;
   localparam logic [3:0] OP_OUT   = 4'd1;
   localparam logic [3:0] OP_JUMP  = 4'd2;
   localparam logic [3:0] OP_JCOND = 4'd3;
   localparam logic [3:0] OP_LOOP  = 4'd4;
   localparam logic [3:0] OP_DJNZ  = 4'd5;
   localparam logic [3:0] OP_WAIT  = 4'd6;
   localparam logic [3:0] OP_CALL  = 4'd7;
   localparam logic [3:0] OP_RET   = 4'd8;
   localparam logic [3:0] OP_HALT  = 4'd15;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StExec,
      StWait,
      StHalt
   } state_e;

endpackage

// File: rtl/useq_stack.sv
// useq_stack: small LIFO used as the sequencer's return-address stack.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset (empties the stack)
//   i_push, i_data      push i_data; ignored when full
//   i_pop               pop the top entry; ignored when empty
//   o_data              current top of stack (valid when not empty)
//   o_full, o_empty     occupancy flags
module useq_stack #(
   parameter int unsigned ENTRIES = 4,
   parameter int unsigned WIDTH   = 9
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int unsigned SpW  = $clog2(ENTRIES + 1);
   localparam int unsigned IdxW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

   logic [SpW-1:0]   r_sp;
   logic [WIDTH-1:0] r_mem [ENTRIES];
   logic [IdxW-1:0]  w_wr_idx;
   logic [IdxW-1:0]  w_rd_idx;

   assign o_full   = (r_sp == SpW'(ENTRIES));
   assign o_empty  = (r_sp == '0);
   assign w_wr_idx = IdxW'(r_sp);
   assign w_rd_idx = IdxW'(r_sp - SpW'(1));
   assign o_data   = r_mem[w_rd_idx];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sp <= '0;
      end else if (i_push && !o_full) begin
         r_mem[w_wr_idx] <= i_data;
         r_sp            <= r_sp + SpW'(1);
      end else if (i_pop && !o_empty) begin
         r_sp <= r_sp - SpW'(1);
      end
   end

endmodule

// File: rtl/useq_sequencer.sv
// useq_sequencer: microcode sequencer. Fetches microwords from a synchronous ROM
// (1-cycle latency, address echoed back) and executes them.
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_start          start pulse; honoured only in idle or halted
//   i_cond[3:0]      external conditions tested by JCOND
//   o_rom_en         ROM read enable (fetch cycle only)
//   o_rom_addr       ROM read address, always equal to the PC
//   i_rom_daddr      address echoed by the ROM alongside i_rom_dout
//   i_rom_dout       fetched microword
//   o_leds[15:0]     registered LED output
//   o_busy           fetching, executing or waiting
//   o_halted         halted
//   o_err            sticky error; cleared by reset or start
// Build option: define USEQ_CALL_STACK_EN to enable CALL/RET with a STACK_DEPTH-entry
// return stack. Without it, CALL and RET are treated as illegal ops.
module useq_sequencer #(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned DEPTH       = 9,
   parameter int unsigned START_ADDR  = 0,
   parameter int unsigned STACK_DEPTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [3:0]       i_cond,
   output logic             o_rom_en,
   output logic [DEPTH-1:0] o_rom_addr,
   input  logic [DEPTH-1:0] i_rom_daddr,
   input  logic [WIDTH-1:0] i_rom_dout,
   output logic [15:0]      o_leds,
   output logic             o_busy,
   output logic             o_halted,
   output logic             o_err
);

   import useq_pkg::*;

   if (WIDTH != 32 || STACK_DEPTH < 1) begin : g_param_check
      $error("useq_sequencer: WIDTH must be 32 and STACK_DEPTH at least 1");
   end

   state_e           r_state, w_state_n;
   logic [DEPTH-1:0] r_pc, w_pc_n;
   logic [15:0]      r_cnt, w_cnt_n;
   logic [15:0]      r_delay, w_delay_n;
   logic [15:0]      r_leds, w_leds_n;
   logic             r_err, w_err_n;

   logic [3:0]       w_op;
   logic [DEPTH-1:0] w_tgt;
   logic [2:0]       w_csel;
   logic [15:0]      w_imm;
   logic [DEPTH-1:0] w_pc_inc;
   logic             w_taken;

   assign w_op     = i_rom_dout[OP_HI:OP_LO];
   assign w_tgt    = DEPTH'(i_rom_dout[TGT_HI:TGT_LO]);
   assign w_csel   = i_rom_dout[CSEL_HI:CSEL_LO];
   assign w_imm    = i_rom_dout[IMM_HI:IMM_LO];
   assign w_pc_inc = r_pc + DEPTH'(1);   // wraps modulo 2^DEPTH
   assign w_taken  = i_cond[w_csel[1:0]] ^ w_csel[2];

`ifdef USEQ_CALL_STACK_EN
   logic             w_push, w_pop, w_full, w_empty;
   logic [DEPTH-1:0] w_ret_addr;

   useq_stack #(
      .ENTRIES (STACK_DEPTH),
      .WIDTH   (DEPTH)
   ) u_stack (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (w_pc_inc),
      .o_data  (w_ret_addr),
      .o_full  (w_full),
      .o_empty (w_empty)
   );
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= StIdle;
         r_pc    <= DEPTH'(START_ADDR);
         r_cnt   <= '0;
         r_delay <= '0;
         r_leds  <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_pc    <= w_pc_n;
         r_cnt   <= w_cnt_n;
         r_delay <= w_delay_n;
         r_leds  <= w_leds_n;
         r_err   <= w_err_n;
      end
   end

   always_comb begin
      w_state_n = r_state;
      w_pc_n    = r_pc;
      w_cnt_n   = r_cnt;
      w_delay_n = r_delay;
      w_leds_n  = r_leds;
      w_err_n   = r_err;
`ifdef USEQ_CALL_STACK_EN
      w_push    = 1'b0;
      w_pop     = 1'b0;
`endif
      unique case (r_state)
         StIdle, StHalt: begin
            if (i_start) begin
               w_state_n = StFetch;
               w_pc_n    = DEPTH'(START_ADDR);
               w_err_n   = 1'b0;
            end
         end
         StFetch: w_state_n = StExec;
         StExec: begin
            if (i_rom_daddr != r_pc) begin
               // Data does not belong to the address we asked for: stop rather than
               // execute a word from the wrong location.
               w_err_n   = 1'b1;
               w_state_n = StHalt;
            end else begin
               w_state_n = StFetch;
               case (w_op)
                  OP_NOP: w_pc_n = w_pc_inc;
                  OP_OUT: begin
                     w_leds_n = w_imm;
                     w_pc_n   = w_pc_inc;
                  end
                  OP_JUMP:  w_pc_n = w_tgt;
                  OP_JCOND: w_pc_n = w_taken ? w_tgt : w_pc_inc;
                  OP_LOOP: begin
                     w_cnt_n = w_imm;
                     w_pc_n  = w_pc_inc;
                  end
                  OP_DJNZ: begin
                     if (r_cnt != '0) begin
                        w_cnt_n = r_cnt - 16'd1;
                        w_pc_n  = w_tgt;
                     end else begin
                        w_pc_n = w_pc_inc;
                     end
                  end
                  OP_WAIT: begin
                     if (w_imm == '0) begin
                        w_pc_n = w_pc_inc;
                     end else begin
                        // imm wait cycles in total: this load plus counting down to zero.
                        w_delay_n = w_imm - 16'd1;
                        w_state_n = StWait;
                     end
                  end
`ifdef USEQ_CALL_STACK_EN
                  OP_CALL: begin
                     if (w_full) begin
                        w_err_n   = 1'b1;
                        w_state_n = StHalt;
                     end else begin
                        w_push = 1'b1;
                        w_pc_n = w_tgt;
                     end
                  end
                  OP_RET: begin
                     if (w_empty) begin
                        w_err_n   = 1'b1;
                        w_state_n = StHalt;
                     end else begin
                        w_pop  = 1'b1;
                        w_pc_n = w_ret_addr;
                     end
                  end
`endif
                  OP_HALT: w_state_n = StHalt;
                  default: begin
                     w_err_n   = 1'b1;
                     w_state_n = StHalt;
                  end
               endcase
            end
         end
         StWait: begin
            if (r_delay == '0) begin
               w_pc_n    = w_pc_inc;
               w_state_n = StFetch;
            end else begin
               w_delay_n = r_delay - 16'd1;
            end
         end
         default: w_state_n = StIdle;
      endcase
   end

   assign o_rom_en   = (r_state == StFetch);
   assign o_rom_addr = r_pc;
   assign o_leds     = r_leds;
   assign o_busy     = (r_state == StFetch) || (r_state == StExec) || (r_state == StWait);
   assign o_halted   = (r_state == StHalt);
   assign o_err      = r_err;

endmodule

// File: tb/tb_useq_sequencer.sv
// tb_useq_sequencer: directed programs run through useq_sequencer with a ROM model.
// An instruction-level interpreter turns each program into the expected per-cycle
// output trace, which is compared against the DUT every cycle; literal checks pin
// the key timings and results.
module tb_useq_sequencer;

   localparam int unsigned DEPTH       = 9;
   localparam int unsigned STACK_DEPTH = 4;

   typedef struct packed {
      logic        en;
      logic [8:0]  addr;
      logic [15:0] leds;
      logic        busy;
      logic        halted;
      logic        err;
   } obs_t;

   logic        clk;
   logic        rst;
   logic        start;
   logic [3:0]  cond;
   logic        rom_en;
   logic [8:0]  rom_addr;
   logic [8:0]  rom_daddr;
   logic [31:0] rom_dout;
   logic [15:0] leds;
   logic        busy;
   logic        halted;
   logic        err;

   int vectors     = 0;
   int miscompares = 0;

   logic [31:0] rom [512];
   bit          flip_daddr;

   // Model state carried between programs (start does not clear these)
   logic [15:0] m_leds;
   logic [15:0] m_cnt;
   logic [8:0]  m_stack [$];
   bit          m_err;
   obs_t        exp_q [$];

   // Observations of the latest run
   int          fetch_cnt   [512];
   int          fetch_first [512];
   logic [8:0]  fetch_seq [$];
   int          first_halt;
   obs_t        last_obs;

   useq_sequencer #(
      .WIDTH       (32),
      .DEPTH       (DEPTH),
      .START_ADDR  (0),
      .STACK_DEPTH (STACK_DEPTH)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_start     (start),
      .i_cond      (cond),
      .o_rom_en    (rom_en),
      .o_rom_addr  (rom_addr),
      .i_rom_daddr (rom_daddr),
      .i_rom_dout  (rom_dout),
      .o_leds      (leds),
      .o_busy      (busy),
      .o_halted    (halted),
      .o_err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rom_en) begin
         rom_dout  <= rom[rom_addr];
         rom_daddr <= flip_daddr ? (rom_addr ^ 9'd1) : rom_addr;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] mk(input int op, input int tgt, input int csel, input int imm);
      return {op[3:0], tgt[8:0], csel[2:0], imm[15:0]};
   endfunction

   function automatic obs_t mk_obs(input logic en, input logic [8:0] addr,
                                   input logic [15:0] l, input logic b, input logic h,
                                   input logic e);
      obs_t o;
      o.en = en; o.addr = addr; o.leds = l; o.busy = b; o.halted = h; o.err = e;
      return o;
   endfunction

   function automatic obs_t cur_obs();
      return mk_obs(rom_en, rom_addr, leds, busy, halted, err);
   endfunction

   task automatic clear_rom();
      for (int a = 0; a < 512; a++) rom[a] = mk(15, 0, 0, 0);
   endtask

   // Interpret the program from address 0: every instruction costs a fetch and an
   // execute cycle, WAIT adds imm cycles, and a stop leaves the halted state visible.
   task automatic build_trace();
      logic [8:0]  pc;
      logic [31:0] w;
      int          op;
      logic [8:0]  tgt;
      logic [2:0]  csel;
      logic [15:0] imm;
      bit          done;
      pc = 9'd0;
      done = 0;
      m_err = 0;
      exp_q.delete();
      for (int steps = 0; steps < 200 && !done; steps++) begin
         w    = rom[pc];
         op   = int'(w[31:28]);
         tgt  = w[27:19];
         csel = w[18:16];
         imm  = w[15:0];
         exp_q.push_back(mk_obs(1'b1, pc, m_leds, 1'b1, 1'b0, 1'b0));
         exp_q.push_back(mk_obs(1'b0, pc, m_leds, 1'b1, 1'b0, 1'b0));
         if (flip_daddr) begin
            m_err = 1;
            done  = 1;
         end else begin
            case (op)
               0: pc = pc + 9'd1;
               1: begin m_leds = imm; pc = pc + 9'd1; end
               2: pc = tgt;
               3: pc = (cond[csel[1:0]] ^ csel[2]) ? tgt : pc + 9'd1;
               4: begin m_cnt = imm; pc = pc + 9'd1; end
               5: begin
                  if (m_cnt != 0) begin m_cnt = m_cnt - 16'd1; pc = tgt; end
                  else pc = pc + 9'd1;
               end
               6: begin
                  for (int i = 0; i < int'(imm); i++)
                     exp_q.push_back(mk_obs(1'b0, pc, m_leds, 1'b1, 1'b0, 1'b0));
                  pc = pc + 9'd1;
               end
`ifdef USEQ_CALL_STACK_EN
               7: begin
                  if (m_stack.size() == STACK_DEPTH) begin m_err = 1; done = 1; end
                  else begin m_stack.push_back(pc + 9'd1); pc = tgt; end
               end
               8: begin
                  if (m_stack.size() == 0) begin m_err = 1; done = 1; end
                  else pc = m_stack.pop_back();
               end
`endif
               15: done = 1;
               default: begin m_err = 1; done = 1; end
            endcase
         end
      end
      if (done) begin
         for (int i = 0; i < 3; i++)
            exp_q.push_back(mk_obs(1'b0, pc, m_leds, 1'b0, 1'b1, m_err));
      end
   endtask

   task automatic check_obs(input string name, input int cyc, input obs_t want);
      obs_t got;
      got = cur_obs();
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s cycle %0d: got en=%0b addr=%0h leds=%0h busy=%0b halted=%0b err=%0b, required en=%0b addr=%0h leds=%0h busy=%0b halted=%0b err=%0b",
                  name, cyc, got.en, got.addr, got.leds, got.busy, got.halted, got.err,
                  want.en, want.addr, want.leds, want.busy, want.halted, want.err);
      end
   endtask

   task automatic check_int(input string name, input int got, input int want);
      vectors++;
      if (got != want) begin
         miscompares++;
         $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, got, got, want, want);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_leds = '0;
      m_cnt  = '0;
      m_stack.delete();
      check_obs("reset_state", 0, mk_obs(1'b0, 9'd0, 16'd0, 1'b0, 1'b0, 1'b0));
   endtask

   // Pulse start, then compare every cycle against the model trace (up to max_cyc).
   // glitch > 0 raises start again in that cycle, which must be ignored while busy.
   task automatic run_prog(input string name, input int max_cyc, input int glitch);
      obs_t o;
      build_trace();
      for (int a = 0; a < 512; a++) begin
         fetch_cnt[a]   = 0;
         fetch_first[a] = -1;
      end
      fetch_seq.delete();
      first_halt = -1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= max_cyc && c <= exp_q.size(); c++) begin
         o = cur_obs();
         if (o.en === 1'b1) begin
            fetch_cnt[o.addr]++;
            if (fetch_first[o.addr] < 0) fetch_first[o.addr] = c;
            fetch_seq.push_back(o.addr);
         end
         if (o.halted === 1'b1 && first_halt < 0) first_halt = c;
         check_obs(name, c, exp_q[c-1]);
         last_obs = o;
         if (c == glitch) start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
   endtask

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      cond       = 4'b0000;
      flip_daddr = 0;
      m_leds     = '0;
      m_cnt      = '0;
      clear_rom();
      repeat (3) @(negedge clk);
      do_reset();

      // OUT then HALT
      clear_rom();
      rom[0] = mk(1, 0, 0, 16'h00A5);
      rom[1] = mk(15, 0, 0, 0);
      run_prog("out_halt", 100, 0);
      check_int("out_halt_fetch0_cycle", fetch_first[0], 1);
      check_int("out_halt_fetch1_cycle", fetch_first[1], 3);
      check_int("out_halt_halt_cycle", first_halt, 5);
      check_int("out_halt_leds", int'(last_obs.leds), 16'h00A5);
      check_int("out_halt_err", int'(last_obs.err), 0);

      // LOOP/DJNZ, with a start pulse mid-run that must be ignored
      clear_rom();
      rom[0] = mk(4, 0, 0, 3);
      rom[1] = mk(1, 0, 0, 1);
      rom[2] = mk(5, 1, 0, 0);
      rom[3] = mk(15, 0, 0, 0);
      run_prog("loop", 100, 6);
      check_int("loop_addr1_fetches", fetch_cnt[1], 4);
      check_int("loop_halt_cycle", first_halt, 21);

      // WAIT 5
      clear_rom();
      rom[0] = mk(6, 0, 0, 5);
      rom[1] = mk(15, 0, 0, 0);
      run_prog("wait5", 100, 0);
      check_int("wait5_fetch_gap", fetch_first[1] - fetch_first[0], 7);

      // JCOND taken / not taken
      clear_rom();
      rom[0]     = mk(3, 9'h010, 3'b010, 0);
      rom[9'h10] = mk(15, 0, 0, 0);
      cond = 4'b0100;
      run_prog("jcond_taken", 100, 0);
      check_int("jcond_taken_next", fetch_seq.size() > 1 ? int'(fetch_seq[1]) : -1, 16);
      cond = 4'b0000;
      run_prog("jcond_not_taken", 100, 0);
      check_int("jcond_not_taken_next", fetch_seq.size() > 1 ? int'(fetch_seq[1]) : -1, 1);

      // PC wrap from 511 to 0, using a loop count left over from a previous program
      clear_rom();
      rom[0] = mk(4, 0, 0, 2);
      run_prog("set_cnt", 100, 0);
      clear_rom();
      rom[0]   = mk(5, 511, 0, 0);
      rom[511] = mk(0, 0, 0, 0);
      run_prog("wrap", 100, 0);
      check_int("wrap_addr0_fetches", fetch_cnt[0], 3);
      check_int("wrap_addr511_fetches", fetch_cnt[511], 2);

      // Illegal op 9
      clear_rom();
      rom[0] = mk(1, 0, 0, 16'h0F0F);
      rom[1] = mk(9, 0, 0, 0);
      run_prog("illegal", 100, 0);
      check_int("illegal_err", int'(last_obs.err), 1);
      check_int("illegal_pc_holds", int'(last_obs.addr), 1);

      // Echoed address mismatch
      clear_rom();
      rom[0] = mk(1, 0, 0, 16'h1234);
      flip_daddr = 1;
      run_prog("daddr_flip", 100, 0);
      flip_daddr = 0;
      check_int("daddr_flip_err", int'(last_obs.err), 1);
      check_int("daddr_flip_halted", int'(last_obs.halted), 1);

      // Restart clears err
      run_prog("restart", 100, 0);
      check_int("restart_err_cleared", int'(last_obs.err), 0);

      // Reset while waiting
      clear_rom();
      rom[0] = mk(1, 0, 0, 16'h5A5A);
      rom[1] = mk(6, 0, 0, 20);
      run_prog("rst_in_wait", 8, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_leds = '0;
      m_cnt  = '0;
      m_stack.delete();
      check_obs("rst_in_wait_idle", 0, mk_obs(1'b0, 9'd0, 16'd0, 1'b0, 1'b0, 1'b0));

`ifdef USEQ_CALL_STACK_EN
      clear_rom();
      rom[0] = mk(7, 8, 0, 0);
      rom[8] = mk(1, 0, 0, 16'h0077);
      rom[9] = mk(8, 0, 0, 0);
      run_prog("call_ret", 100, 0);
      check_int("call_ret_return_addr", fetch_seq.size() > 3 ? int'(fetch_seq[3]) : -1, 1);
      check_int("call_ret_err", int'(last_obs.err), 0);
      clear_rom();
      rom[0] = mk(8, 0, 0, 0);
      run_prog("ret_underflow", 100, 0);
      check_int("ret_underflow_err", int'(last_obs.err), 1);
      clear_rom();
      for (int i = 0; i < 5; i++) rom[i] = mk(7, i + 1, 0, 0);
      run_prog("call_overflow", 100, 0);
      check_int("call_overflow_err", int'(last_obs.err), 1);
      check_int("call_overflow_addr", int'(last_obs.addr), 4);
`else
      clear_rom();
      rom[0] = mk(7, 4, 0, 0);
      run_prog("call_illegal", 100, 0);
      check_int("call_illegal_err", int'(last_obs.err), 1);
      check_int("call_illegal_halted", int'(last_obs.halted), 1);
      check_int("call_illegal_addr", int'(last_obs.addr), 0);
      clear_rom();
      rom[0] = mk(8, 0, 0, 0);
      run_prog("ret_illegal", 100, 0);
      check_int("ret_illegal_err", int'(last_obs.err), 1);
`endif
      do_reset();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
